// File: rtl/adder_axil_pkg.sv
// Shared definitions for the two-requester AXI-Lite master in front of the adder slave.
// Holds the FSM state encoding, requester count and the OKAY response code.
package adder_axil_pkg;

  localparam int   NUM_REQ   = 2;
  localparam logic RESP_OKAY = 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant from the request vector and a
// registered priority pointer that moves to the other requester when a transaction retires.
module rr_arbiter_2
  import adder_axil_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic               last_grant,
  output logic               grant,
  output logic               grant_valid
);

  logic ptr;

  // The pointer's requester wins if it is asking; otherwise the other one gets it.
  always_comb begin
    grant_valid = |req;
    grant       = req[ptr] ? ptr : ~ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~last_grant;
    end
  end

endmodule

// File: rtl/adder_axil_arbiter.sv
// AXI-Lite master sharing the adder slave between two req/ack command sources.
// One single-beat transaction in flight; every output comes straight from a flop.
module adder_axil_arbiter
  import adder_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          m1_axi_aclk,
  input  logic                          m1_axi_areset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         m1_axi_awaddr,
  output logic                          m1_axi_awvalid,
  input  logic                          m1_axi_awready,
  output logic [DATA_WIDTH-1:0]         m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]       m1_axi_wstrb,
  output logic                          m1_axi_wvalid,
  input  logic                          m1_axi_wready,
  input  logic                          m1_axi_bresp,
  input  logic                          m1_axi_bvalid,
  output logic                          m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m1_axi_araddr,
  output logic                          m1_axi_arvalid,
  input  logic                          m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]         m1_axi_rdata,
  input  logic                          m1_axi_rresp,
  input  logic                          m1_axi_rvalid,
  output logic                          m1_axi_rready
);

  state_t state, state_d;
  logic   grant_q, grant_d;
  logic   arb_grant, arb_any;
  logic   sel_we;
  logic   aw_ok, w_ok;

  logic [ADDR_WIDTH-1:0] sel_addr, awaddr_d, araddr_d;
  logic [DATA_WIDTH-1:0] sel_wdata, wdata_d, rsp_rdata_d;
  logic [NUM_REQ-1:0]    ack_d;
  logic awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_err_d;

  rr_arbiter_2 u_arb (
    .clk         (m1_axi_aclk),
    .rst         (m1_axi_areset),
    .req         (req),
    .update      (state == DONE),
    .last_grant  (grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_any)
  );

  assign sel_we    = req_we[arb_grant];
  assign sel_addr  = arb_grant ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
  assign sel_wdata = arb_grant ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];

  // A write channel counts as finished once its valid has been retired by a handshake.
  assign aw_ok = ~m1_axi_awvalid | m1_axi_awready;
  assign w_ok  = ~m1_axi_wvalid  | m1_axi_wready;

  assign m1_axi_wstrb = '1;

  always_comb begin
    state_d     = state;
    grant_d     = grant_q;
    awaddr_d    = m1_axi_awaddr;
    araddr_d    = m1_axi_araddr;
    wdata_d     = m1_axi_wdata;
    awvalid_d   = m1_axi_awvalid;
    wvalid_d    = m1_axi_wvalid;
    bready_d    = m1_axi_bready;
    arvalid_d   = m1_axi_arvalid;
    rready_d    = m1_axi_rready;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    ack_d       = '0;

    unique case (state)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          if (sel_we) begin
            awaddr_d  = sel_addr;
            wdata_d   = sel_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            araddr_d  = sel_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        awvalid_d = m1_axi_awvalid & ~m1_axi_awready;
        wvalid_d  = m1_axi_wvalid  & ~m1_axi_wready;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m1_axi_bvalid) begin
          bready_d  = 1'b0;
          rsp_err_d = (m1_axi_bresp != RESP_OKAY);
          ack_d     = grant_q ? 2'b10 : 2'b01;
          state_d   = DONE;
        end
      end
      RD_ADDR: begin
        if (m1_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m1_axi_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m1_axi_rdata;
          rsp_err_d   = (m1_axi_rresp != RESP_OKAY);
          ack_d       = grant_q ? 2'b10 : 2'b01;
          state_d     = DONE;
        end
      end
      // The ack pulse is already on the wire; the arbiter pointer moves this cycle.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      state          <= IDLE;
      grant_q        <= 1'b0;
      m1_axi_awaddr  <= '0;
      m1_axi_araddr  <= '0;
      m1_axi_wdata   <= '0;
      m1_axi_awvalid <= 1'b0;
      m1_axi_wvalid  <= 1'b0;
      m1_axi_bready  <= 1'b0;
      m1_axi_arvalid <= 1'b0;
      m1_axi_rready  <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      ack            <= '0;
    end else begin
      state          <= state_d;
      grant_q        <= grant_d;
      m1_axi_awaddr  <= awaddr_d;
      m1_axi_araddr  <= araddr_d;
      m1_axi_wdata   <= wdata_d;
      m1_axi_awvalid <= awvalid_d;
      m1_axi_wvalid  <= wvalid_d;
      m1_axi_bready  <= bready_d;
      m1_axi_arvalid <= arvalid_d;
      m1_axi_rready  <= rready_d;
      rsp_rdata      <= rsp_rdata_d;
      rsp_err        <= rsp_err_d;
      ack            <= ack_d;
    end
  end

endmodule

// File: tb/tb_adder_axil_arbiter.sv
// Scoreboard bench for adder_axil_arbiter: directed commands push expected acks and AXI
// beats into queues; a behavioural slave and an ack monitor pop and compare independently.
module tb_adder_axil_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req, req_we, ack;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        bresp, bvalid, bready;
  logic        arvalid, arready, rresp, rvalid, rready;

  adder_axil_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .m1_axi_aclk    (clk),
    .m1_axi_areset  (rst),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ack            (ack),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .m1_axi_awaddr  (awaddr),
    .m1_axi_awvalid (awvalid),
    .m1_axi_awready (awready),
    .m1_axi_wdata   (wdata),
    .m1_axi_wstrb   (wstrb),
    .m1_axi_wvalid  (wvalid),
    .m1_axi_wready  (wready),
    .m1_axi_bresp   (bresp),
    .m1_axi_bvalid  (bvalid),
    .m1_axi_bready  (bready),
    .m1_axi_araddr  (araddr),
    .m1_axi_arvalid (arvalid),
    .m1_axi_arready (arready),
    .m1_axi_rdata   (rdata),
    .m1_axi_rresp   (rresp),
    .m1_axi_rvalid  (rvalid),
    .m1_axi_rready  (rready)
  );

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        who;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  cmd_t cmdq0[$], cmdq1[$];
  exp_t expq[$];
  cmd_t axiq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_total = 0;

  // Slave behaviour knobs and per-transaction valid/ready occupancy counters.
  int   aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
  logic bresp_val = 1'b0, rresp_val = 1'b0;
  int   last_aw = 0, last_w = 0, last_b = 0;

  cmd_t   cur0, cur1;
  bit     cv0 = 0, cv1 = 0;
  longint issue_t0 = 0, issue_t1 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int who, input logic we, input logic [7:0] addr,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input logic exp_err, input int lat, input bit expect_ack);
    cmd_t c;
    exp_t e;
    c.we = we; c.addr = addr; c.wdata = wd;
    if (who == 0) cmdq0.push_back(c); else cmdq1.push_back(c);
    axiq.push_back(c);
    if (expect_ack) begin
      e.who = (who != 0); e.err = exp_err; e.chk_rd = ~we; e.rdata = exp_rd; e.lat = lat;
      expq.push_back(e);
    end
  endtask

  task automatic waitIdle(input int max_cycles);
    int n = 0;
    while (!(expq.size() == 0 && cmdq0.size() == 0 && cmdq1.size() == 0 && !cv0 && !cv1)
           && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!(expq.size() == 0 && cmdq0.size() == 0 && cmdq1.size() == 0 && !cv0 && !cv1)) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_idle_timeout: got %0d acks pending, expected 0", expq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valids"}, {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    checkOutput({tag, "_ack"}, {30'd0, ack}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, "_addrs"}, {16'd0, awaddr, araddr}, 32'd0);
    checkOutput({tag, "_wdata"}, wdata, 32'd0);
    checkOutput({tag, "_wstrb"}, {28'd0, wstrb}, 32'hF);
  endtask

  // Requester driver: holds each command until its ack is seen, then loads the next.
  initial begin
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cur0 = '0; cur1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cv0 = 0; cv1 = 0;
      end else begin
        if (ack[0]) cv0 = 0;
        if (ack[1]) cv1 = 0;
        if (!cv0 && cmdq0.size() > 0) begin cur0 = cmdq0.pop_front(); cv0 = 1; issue_t0 = longint'($time); end
        if (!cv1 && cmdq1.size() > 0) begin cur1 = cmdq1.pop_front(); cv1 = 1; issue_t1 = longint'($time); end
      end
      req       = {cv1, cv0};
      req_we    = {cur1.we, cur0.we};
      req_addr  = {cur1.addr, cur0.addr};
      req_wdata = {cur1.wdata, cur0.wdata};
    end
  end

  // Ack monitor: every ack pulse must match the head of the expectation queue.
  initial begin
    exp_t   e;
    longint lat;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && ack != 2'b00) begin
        ack_total++;
        if (ack == 2'b11) begin
          checkOutput("ack_onehot", {30'd0, ack}, 32'd1);
        end else if (expq.size() == 0) begin
          checkOutput("unexpected_ack", {30'd0, ack}, 32'd0);
        end else begin
          e = expq.pop_front();
          checkOutput("ack_requester", {31'd0, ack[1]}, {31'd0, e.who});
          checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          if (e.chk_rd) checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          if (e.lat >= 0) begin
            lat = (longint'($time) - (e.who ? issue_t1 : issue_t0) + 4) / 10;
            checkOutput("ack_latency", lat[31:0], e.lat);
          end
        end
      end
    end
  end

  // Behavioural AXI-Lite slave: samples handshakes on rising edges, drives on falling edges.
  initial begin
    logic [31:0] mem [256];
    bit got_aw, got_w, b_pend, r_pend;
    int aw_cnt, w_cnt, b_cnt, r_cnt, aw_hi, w_hi, b_hi;
    logic [7:0]  aw_addr_s;
    logic [31:0] w_data_s, r_data_s;
    logic [3:0]  w_strb_s;
    cmd_t x;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; aw_hi = 0; w_hi = 0; b_hi = 0;
    aw_addr_s = '0; w_data_s = '0; r_data_s = '0; w_strb_s = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; aw_hi = 0; w_hi = 0; b_hi = 0;
      end else begin
        if (awvalid) aw_hi++;
        if (wvalid)  w_hi++;
        if (bready)  b_hi++;
        if (awvalid && awready) begin got_aw = 1; aw_addr_s = awaddr; last_aw = aw_hi; aw_hi = 0; aw_cnt = 0; end
        if (wvalid && wready) begin got_w = 1; w_data_s = wdata; w_strb_s = wstrb; last_w = w_hi; w_hi = 0; w_cnt = 0; end
        if (bvalid && bready) begin b_pend = 0; last_b = b_hi; b_hi = 0; end
        if (got_aw && got_w) begin
          mem[aw_addr_s] = w_data_s;
          if (axiq.size() == 0) begin
            checkOutput("unexpected_write", {24'd0, aw_addr_s}, 32'hFFFF_FFFF);
          end else begin
            x = axiq.pop_front();
            checkOutput("axi_is_write", {31'd0, x.we}, 32'd1);
            checkOutput("awaddr", {24'd0, aw_addr_s}, {24'd0, x.addr});
            checkOutput("wdata", w_data_s, x.wdata);
            checkOutput("wstrb", {28'd0, w_strb_s}, 32'hF);
          end
          got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
        end
        if (arvalid && arready) begin
          if (axiq.size() == 0) begin
            checkOutput("unexpected_read", {24'd0, araddr}, 32'hFFFF_FFFF);
          end else begin
            x = axiq.pop_front();
            checkOutput("axi_is_read", {31'd0, x.we}, 32'd0);
            checkOutput("araddr", {24'd0, araddr}, {24'd0, x.addr});
          end
          r_pend = 1; r_cnt = 0; r_data_s = mem[araddr];
        end
        if (rvalid && rready) r_pend = 0;
      end
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0;
      end else begin
        awready = awvalid && !got_aw && (aw_cnt >= aw_delay);
        if (awvalid && !got_aw) aw_cnt++;
        wready = wvalid && !got_w && (w_cnt >= w_delay);
        if (wvalid && !got_w) w_cnt++;
        bvalid = b_pend && (b_cnt >= b_delay);
        bresp  = bresp_val;
        if (b_pend) b_cnt++;
        arready = arvalid && !r_pend;
        rvalid  = r_pend && (r_cnt >= r_delay);
        rdata   = rvalid ? r_data_s : 32'd0;
        rresp   = rresp_val;
        if (r_pend) r_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks_before;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single write from requester 0");
    applyStimulus(0, 1'b1, 8'h04, 32'd23, 32'd0, 1'b0, 3, 1);
    waitIdle(50);
    checkOutput("wr_aw_cycles", last_aw, 32'd1);
    checkOutput("wr_w_cycles", last_w, 32'd1);
    checkOutput("wr_b_cycles", last_b, 32'd1);

    $display("[TB] single read from requester 1");
    applyStimulus(1, 1'b0, 8'h04, 32'd0, 32'd23, 1'b0, 3, 1);
    waitIdle(50);

    $display("[TB] contention, six writes each");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1'b1, 8'(k), 32'(23 + 7 * k), 32'd0, 1'b0, -1, 1);
      applyStimulus(1, 1'b1, 8'(k), 32'(23 + 7 * k), 32'd0, 1'b0, -1, 1);
    end
    waitIdle(300);

    $display("[TB] split AW/W handshake");
    aw_delay = 3;
    applyStimulus(0, 1'b1, 8'h10, 32'hA5A5_0001, 32'd0, 1'b0, -1, 1);
    waitIdle(50);
    aw_delay = 0;
    checkOutput("split_aw_cycles", last_aw, 32'd4);
    checkOutput("split_w_cycles", last_w, 32'd1);
    checkOutput("split_b_cycles", last_b, 32'd1);

    $display("[TB] delayed error write response");
    b_delay = 5;
    bresp_val = 1'b1;
    applyStimulus(1, 1'b1, 8'h14, 32'd99, 32'd0, 1'b1, -1, 1);
    waitIdle(60);
    b_delay = 0;
    bresp_val = 1'b0;
    checkOutput("err_b_cycles", last_b, 32'd6);

    $display("[TB] reset during read data phase");
    r_delay = 20;
    acks_before = ack_total;
    applyStimulus(0, 1'b0, 8'h04, 32'd0, 32'd0, 1'b0, -1, 0);
    for (int i = 0; i < 30 && !rready; i++) @(negedge clk);
    checkOutput("reach_rd_data", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    #1;
    checkResetValues("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r_delay = 0;
    repeat (10) @(negedge clk);
    checkOutput("no_ack_after_reset", ack_total - acks_before, 32'd0);
    checkOutput("axi_queue_drained", axiq.size(), 32'd0);

    $display("[TB] read after reset");
    applyStimulus(0, 1'b0, 8'h04, 32'd0, 32'd51, 1'b0, 3, 1);
    waitIdle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
